sc_frame_sequencer: RTL and testbench
=====================================

# sc_frame_sequencer

Sequences the periodic framer stage that follows the Schmidl-Cox detector. On a detector trigger it skips a programmable time offset, then gates the sample stream into up to `max_frames` frames of `frame_len` samples separated by `gap_len` dropped samples (cyclic prefix), marking each frame end with `o_tlast`. Configuration arrives on the block's settings bus at registers 0x10–0x13, the same addresses the framer uses. The block sits between the detector output and the FFT input inside `noc_block_schmidl_cox`.

## Interface
- `SR_FRAME_LEN`, default 16 (0x10): settings address of frame length (FFT size).
- `SR_GAP_LEN`, default 17 (0x11): settings address of gap length (CP).
- `SR_OFFSET`, default 18 (0x12): settings address of trigger-to-first-frame offset.
- `SR_MAX_FRAMES`, default 19 (0x13): settings address of frames per trigger.
- `WIDTH`, default 32: sample width (16I/16Q).
- `CNT_W`, default 16: width of all length/count registers.

Ports:
- `ce_clk`  in  1  clock.
- `ce_rst`  in  1  reset, asynchronous, active-low.
- `set_stb`  in  1  settings write strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data; low `CNT_W` bits used.
- `i_tdata`  in  WIDTH  input sample.
- `i_ttrig`  in  1  detector trigger, sideband qualified by `i_tvalid & i_tready`.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  WIDTH  output sample (= `i_tdata`).
- `o_tlast`  out  1  last sample of frame.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `busy`  out  1  high in any state other than IDLE.
- `frame_cnt`  out  CNT_W  frames completed since the last trigger.

## Operation
- Shadow registers are written on `set_stb` when `set_addr` matches. Reset values: frame_len 64, gap_len 16, offset 0, max_frames 1. Other addresses are ignored.
- Active registers are copied from the shadow registers on each accepted trigger in IDLE. Writes made mid-sequence never affect the running sequence.
- A frame_len of 0 is treated as 1. max_frames 0 means unbounded: frames continue until reset.
- States and transitions (a "beat" is `i_tvalid & i_tready`):
  - IDLE: `i_tready`=1, beats dropped. A beat with `i_ttrig`=1 latches the config and clears `frame_cnt`. It then goes to OFFSET if offset>0 (that beat counts as offset sample 1), else to FRAME (that beat is frame sample 0 and is passed).
  - OFFSET: drop beats. After offset beats in total, go to FRAME.
  - FRAME: pass beats. The frame_len-th beat has `o_tlast`=1 and increments `frame_cnt`. Then:
    - if max_frames≠0 and `frame_cnt`+1 == max_frames, go to IDLE;
    - else if gap_len>0, go to GAP;
    - else stay in FRAME.
  - GAP: drop gap_len beats, then go to FRAME.
- `i_ttrig` is ignored outside IDLE and on dropped beats in OFFSET/GAP.
- Counter arithmetic is unsigned `CNT_W`. `frame_cnt` saturates at all-ones.

## Timing
- Zero-latency pass-through.
  - FRAME: `o_tvalid`=`i_tvalid`, `i_tready`=`o_tready`, `o_tdata`=`i_tdata`.
  - IDLE trigger beat with offset 0: passed combinationally with the same rules, so `i_tready` depends on `o_tready` only when `i_ttrig`=1.
  - All other dropping states: `i_tready`=1, `o_tvalid`=0.
- `o_tlast` is valid only with `o_tvalid`. It stays stable while stalled (`o_tvalid & ~o_tready`).
- State and counters advance only on beats. Stalls hold everything.
- Reset: state IDLE, `busy`=0, `frame_cnt`=0, `o_tvalid`=0, `o_tlast`=0, shadow registers at defaults. Asserting reset mid-frame aborts immediately; no `o_tlast` is emitted for the partial frame.
- A settings write in the same cycle as the trigger beat is not included in the latched config. It applies at the next trigger.

## Test plan
- Config 64/16/20/12 with a ramp input, trigger on ramp value 100 → output begins at 120, 12 frames of 64 with `o_tlast` at 183, 263, …, 1063; gaps 184–199, etc. dropped; `busy` falls after the beat with value 1063; `frame_cnt`=12.
- Offset 0, frame_len 4, gap 0, max 2, trigger on value 7 → values 7–14 output, `o_tlast` on 10 and 14.
- Random `o_tready` stalls (50%) on the first scenario → identical output sequence; no beats lost or duplicated.
- Second trigger during FRAME, plus a write of frame_len=32 mid-sequence → trigger ignored; the current sequence keeps 64. The next trigger in IDLE uses 32.
- max_frames 0, frame_len 8, gap 2 → continuous frames every 10 beats; `frame_cnt` increments past 1000.
- Assert `ce_rst` low mid-frame → all outputs go to their reset values immediately. After release, no output appears until a new trigger, and the defaults 64/16/0/1 are in effect.

Source files
------------

// File: rtl/sc_frame_sequencer_if.sv
// Stream + settings bundle for the Schmidl-Cox frame sequencer.
// The master drives samples/settings; the slave is the sequencer itself.
interface sc_frame_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic               set_stb;
    logic [7:0]         set_addr;
    logic [31:0]        set_data;
    logic [WIDTH-1:0]   i_tdata;
    logic               i_ttrig;
    logic               i_tvalid;
    logic               i_tready;
    logic [WIDTH-1:0]   o_tdata;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;
    logic               busy;
    logic [CNT_W-1:0]   frame_cnt;

    modport master (
        output set_stb, set_addr, set_data, i_tdata, i_ttrig, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid, busy, frame_cnt
    );

    modport slave (
        input  set_stb, set_addr, set_data, i_tdata, i_ttrig, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid, busy, frame_cnt
    );
endinterface

// File: rtl/sc_frame_sequencer.sv
// Trigger-driven framer: skips an offset after a detector trigger, then gates
// the sample stream into frames separated by dropped cyclic-prefix gaps.
module sc_frame_sequencer #(
    parameter int SR_FRAME_LEN  = 16,
    parameter int SR_GAP_LEN    = 17,
    parameter int SR_OFFSET     = 18,
    parameter int SR_MAX_FRAMES = 19,
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 16
) (
    input  logic                ce_clk,
    input  logic                ce_rst,
    sc_frame_sequencer_if.slave bus
);
    localparam logic [7:0]       A_FLEN = 8'(SR_FRAME_LEN);
    localparam logic [7:0]       A_GAP  = 8'(SR_GAP_LEN);
    localparam logic [7:0]       A_OFF  = 8'(SR_OFFSET);
    localparam logic [7:0]       A_MAX  = 8'(SR_MAX_FRAMES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_FRAME, S_GAP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_sh_flen, r_sh_gap, r_sh_off, r_sh_max;
    logic [CNT_W-1:0] r_flen, r_gap, r_off, r_max;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_idle;
    logic [CNT_W-1:0] w_cfg_flen, w_cfg_gap, w_cfg_max;
    logic [CNT_W-1:0] w_flen_m1;
    logic             w_last;
    logic             w_pass;
    logic             w_beat;
    logic [CNT_W-1:0] w_fcnt, w_fcnt_p1, w_fcnt_sat;
    logic             w_stop;
    logic [CNT_W-1:0] w_set_val;
    logic [WIDTH-1:0] w_data;

    // While idle the trigger beat may itself be frame sample 0, so the frame
    // decisions must look at the shadow config that is about to be latched.
    assign w_idle     = (r_state == S_IDLE);
    assign w_cfg_flen = w_idle ? r_sh_flen : r_flen;
    assign w_cfg_gap  = w_idle ? r_sh_gap  : r_gap;
    assign w_cfg_max  = w_idle ? r_sh_max  : r_max;
    assign w_flen_m1  = (w_cfg_flen == '0) ? '0 : w_cfg_flen - ONE;
    assign w_last     = (r_cnt == w_flen_m1);

    assign w_pass = ce_rst & ((r_state == S_FRAME) |
                              (w_idle & bus.i_ttrig & (r_sh_off == '0)));

    assign w_data       = bus.i_tdata;
    assign bus.o_tdata  = w_data;
    assign bus.i_tready = w_pass ? bus.o_tready : 1'b1;
    assign bus.o_tvalid = w_pass & bus.i_tvalid;
    assign bus.o_tlast  = w_pass & bus.i_tvalid & w_last;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.frame_cnt = r_frame_cnt;

    assign w_beat     = bus.i_tvalid & bus.i_tready;
    assign w_fcnt     = w_idle ? '0 : r_frame_cnt;
    assign w_fcnt_p1  = w_fcnt + ONE;
    assign w_fcnt_sat = (&w_fcnt) ? w_fcnt : w_fcnt_p1;
    assign w_stop     = (w_cfg_max != '0) && (w_fcnt_p1 == w_cfg_max);
    assign w_set_val  = bus.set_data[CNT_W-1:0];

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            r_state     <= S_IDLE;
            r_sh_flen   <= CNT_W'(64);
            r_sh_gap    <= CNT_W'(16);
            r_sh_off    <= '0;
            r_sh_max    <= ONE;
            r_flen      <= '0;
            r_gap       <= '0;
            r_off       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (bus.set_stb) begin
                if (bus.set_addr == A_FLEN) r_sh_flen <= w_set_val;
                if (bus.set_addr == A_GAP)  r_sh_gap  <= w_set_val;
                if (bus.set_addr == A_OFF)  r_sh_off  <= w_set_val;
                if (bus.set_addr == A_MAX)  r_sh_max  <= w_set_val;
            end

            if (w_beat) begin
                if (w_idle && bus.i_ttrig) begin
                    r_flen      <= r_sh_flen;
                    r_gap       <= r_sh_gap;
                    r_off       <= r_sh_off;
                    r_max       <= r_sh_max;
                    r_frame_cnt <= '0;
                end

                if (w_pass) begin
                    // Passed beat: either mid-frame or the frame's final sample.
                    if (w_last) begin
                        r_frame_cnt <= w_fcnt_sat;
                        r_cnt       <= '0;
                        if (w_stop)
                            r_state <= S_IDLE;
                        else if (w_cfg_gap != '0)
                            r_state <= S_GAP;
                        else
                            r_state <= S_FRAME;
                    end else begin
                        r_cnt   <= r_cnt + ONE;
                        r_state <= S_FRAME;
                    end
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            // Trigger beat with a non-zero offset is offset sample 1.
                            if (bus.i_ttrig) begin
                                if (r_sh_off == ONE) begin
                                    r_state <= S_FRAME;
                                    r_cnt   <= '0;
                                end else begin
                                    r_state <= S_OFFSET;
                                    r_cnt   <= ONE;
                                end
                            end
                        end
                        S_OFFSET: begin
                            if (r_cnt == r_off - ONE) begin
                                r_state <= S_FRAME;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + ONE;
                            end
                        end
                        S_GAP: begin
                            if (r_cnt == r_gap - ONE) begin
                                r_state <= S_FRAME;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + ONE;
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sc_frame_sequencer.sv
// Bench for sc_frame_sequencer: ramp stimulus with random stalls, expected
// output stream derived arithmetically from the frame/gap/offset rules.
module tb_sc_frame_sequencer;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam logic [7:0] A_FLEN = 8'h10;
    localparam logic [7:0] A_GAP  = 8'h11;
    localparam logic [7:0] A_OFF  = 8'h12;
    localparam logic [7:0] A_MAX  = 8'h13;

    logic ce_clk = 1'b0;
    logic ce_rst = 1'b0;
    always #5 ce_clk = ~ce_clk;

    sc_frame_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sc_frame_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .ce_clk (ce_clk),
        .ce_rst (ce_rst),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int flen;
        int gap;
        int off;
        int maxf;
        int lead;
        int stall;
        int extra;
        int exp_frames;
        int exp_busy;
    } scn_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] ramp   = 0;
    int          stall_pct = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Output monitor: every accepted output beat must match the model queue.
    logic prev_stall = 1'b0;
    logic prev_last  = 1'b0;
    always @(negedge ce_clk) begin
        beat_t e;
        if (ce_rst) begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.o_tvalid), 64'd1);
                check("stall_last_stable", 64'(bus.o_tlast), 64'(prev_last));
            end
            if (bus.o_tvalid && bus.o_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output actual=%0d required=no output", bus.o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.o_tdata), 64'(e.data));
                    check("out_last", 64'(bus.o_tlast), 64'(e.last));
                end
            end
            prev_stall = bus.o_tvalid && !bus.o_tready;
            prev_last  = bus.o_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Expected stream: frame k occupies ramp values start + k*(flen+gap) + [0, flen).
    task automatic build(input longint trig, input int flen, input int gap, input int off,
                         input int maxf, input longint last_val, output int nfr);
        int     fl;
        longint v;
        beat_t  b;
        fl  = (flen == 0) ? 1 : flen;
        nfr = 0;
        for (int k = 0; (maxf == 0) || (k < maxf); k++) begin
            for (int j = 0; j < fl; j++) begin
                v = trig + off + longint'(k) * (fl + gap) + j;
                if (v > last_val) return;
                b.data = 32'(v);
                b.last = (j == fl - 1);
                exp_q.push_back(b);
                if (b.last) nfr++;
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input int d);
        bus.set_stb  = 1'b1;
        bus.set_addr = a;
        bus.set_data = 32'(d);
        bus.i_tvalid = 1'b0;
        @(posedge ce_clk);
        #1;
        bus.set_stb = 1'b0;
    endtask

    task automatic cfg(input int flen, input int gap, input int off, input int maxf);
        wr(A_FLEN, flen);
        wr(A_GAP, gap);
        wr(A_OFF, off);
        wr(A_MAX, maxf);
    endtask

    task automatic send(input logic trig);
        int   n;
        logic got;
        if (stall_pct > 0 && $urandom_range(0, 3) == 0) begin
            bus.i_tvalid = 1'b0;
            bus.i_ttrig  = 1'b0;
            @(posedge ce_clk);
            #1;
        end
        bus.i_tdata  = ramp;
        bus.i_ttrig  = trig;
        bus.i_tvalid = 1'b1;
        n = 0;
        forever begin
            bus.o_tready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge ce_clk);
            got = bus.i_tready;
            @(posedge ce_clk);
            #1;
            bus.set_stb = 1'b0;
            if (got) break;
            n++;
            if (n >= 200) begin
                checks++;
                fails++;
                $display("FAIL beat_timeout value=%0d not accepted, required within 200 cycles", ramp);
                break;
            end
        end
        bus.i_tvalid = 1'b0;
        bus.i_ttrig  = 1'b0;
        ramp++;
    endtask

    scn_t tbl[9];

    initial begin
        int     nfr;
        longint trig, last_val;
        int     fl;

        bus.set_stb  = 1'b0;
        bus.set_addr = '0;
        bus.set_data = '0;
        bus.i_tdata  = '0;
        bus.i_ttrig  = 1'b1;
        bus.i_tvalid = 1'b1;
        bus.o_tready = 1'b1;

        // Reset state, even with a trigger beat presented during reset.
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_o_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("rst_o_tlast", 64'(bus.o_tlast), 64'd0);
        repeat (3) @(posedge ce_clk);
        bus.i_ttrig  = 1'b0;
        bus.i_tvalid = 1'b0;
        #1;
        ce_rst = 1'b1;
        @(posedge ce_clk);
        #1;

        //            flen gap off maxf lead stall extra frames busy
        tbl[0] = '{64, 16, 20, 12, 100, 0, 5, 12, 0};
        tbl[1] = '{64, 16, 20, 12,   3, 1, 5, 12, 0};
        tbl[2] = '{ 4,  0,  0,  2,   7, 0, 4,  2, 0};
        tbl[3] = '{ 0,  1,  1,  3,   2, 1, 3,  3, 0};
        tbl[4] = '{ 1,  0,  0,  1,   1, 1, 3,  1, 0};
        for (int i = 5; i < 9; i++) begin
            tbl[i].flen  = $urandom_range(0, 20);
            tbl[i].gap   = $urandom_range(0, 5);
            tbl[i].off   = $urandom_range(0, 10);
            tbl[i].maxf  = $urandom_range(1, 5);
            tbl[i].lead  = $urandom_range(0, 5);
            tbl[i].stall = $urandom_range(0, 1);
            tbl[i].extra = 3;
            tbl[i].exp_frames = tbl[i].maxf;
            tbl[i].exp_busy   = 0;
        end

        for (int i = 0; i < 9; i++) begin
            cfg(tbl[i].flen, tbl[i].gap, tbl[i].off, tbl[i].maxf);
            stall_pct = (tbl[i].stall != 0) ? 50 : 0;
            fl = (tbl[i].flen == 0) ? 1 : tbl[i].flen;
            trig = longint'(ramp) + tbl[i].lead;
            last_val = trig + tbl[i].off + longint'(tbl[i].maxf) * (fl + tbl[i].gap) + tbl[i].extra;
            build(trig, tbl[i].flen, tbl[i].gap, tbl[i].off, tbl[i].maxf, last_val, nfr);
            while (longint'(ramp) <= last_val) send(longint'(ramp) == trig);
            $display("scenario %0d: flen=%0d gap=%0d off=%0d max=%0d trig=%0d frame_cnt=%0d busy=%0d",
                     i, tbl[i].flen, tbl[i].gap, tbl[i].off, tbl[i].maxf, trig, bus.frame_cnt, bus.busy);
            check("scn_frame_cnt", 64'(bus.frame_cnt), 64'(tbl[i].exp_frames));
            check("scn_busy", 64'(bus.busy), 64'(tbl[i].exp_busy));
            check("scn_drained", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        stall_pct = 0;

        // Mid-sequence trigger in FRAME and GAP plus a frame_len write: ignored.
        cfg(64, 16, 5, 2);
        trig = longint'(ramp) + 2;
        last_val = trig + 5 + 2 * 80 + 3;
        build(trig, 64, 16, 5, 2, last_val, nfr);
        while (longint'(ramp) <= last_val) begin
            if (longint'(ramp) == trig + 30) wr(A_FLEN, 32);
            send((longint'(ramp) == trig) || (longint'(ramp) == trig + 15) ||
                 (longint'(ramp) == trig + 72));
        end
        $display("midseq: frame_cnt=%0d busy=%0d", bus.frame_cnt, bus.busy);
        check("midseq_frame_cnt", 64'(bus.frame_cnt), 64'd2);
        check("midseq_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Next trigger uses 32; a frame_len write on the trigger beat waits a sequence.
        trig = longint'(ramp) + 1;
        last_val = trig + 5 + 2 * 48 + 3;
        build(trig, 32, 16, 5, 2, last_val, nfr);
        while (longint'(ramp) <= last_val) begin
            if (longint'(ramp) == trig) begin
                bus.set_stb  = 1'b1;
                bus.set_addr = A_FLEN;
                bus.set_data = 32'd8;
            end
            send(longint'(ramp) == trig);
        end
        $display("new32: frame_cnt=%0d busy=%0d", bus.frame_cnt, bus.busy);
        check("new32_frame_cnt", 64'(bus.frame_cnt), 64'd2);
        check("new32_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        trig = longint'(ramp) + 1;
        last_val = trig + 5 + 2 * 24 + 3;
        build(trig, 8, 16, 5, 2, last_val, nfr);
        while (longint'(ramp) <= last_val) send(longint'(ramp) == trig);
        $display("late8: frame_cnt=%0d busy=%0d", bus.frame_cnt, bus.busy);
        check("late8_frame_cnt", 64'(bus.frame_cnt), 64'd2);
        check("late8_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Unbounded frames, stopping mid-frame.
        cfg(8, 2, 0, 0);
        trig = longint'(ramp) + 1;
        last_val = trig + 1005 * 10 + 4;
        build(trig, 8, 2, 0, 0, last_val, nfr);
        while (longint'(ramp) <= last_val) send(longint'(ramp) == trig);
        $display("unbounded: frame_cnt=%0d busy=%0d", bus.frame_cnt, bus.busy);
        check("unb_frame_cnt", 64'(bus.frame_cnt), 64'(nfr));
        check("unb_past_1000", 64'(bus.frame_cnt > 16'd1000), 64'd1);
        check("unb_busy", 64'(bus.busy), 64'd1);
        check("unb_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset mid-frame with a live beat presented.
        bus.i_tdata  = ramp;
        bus.i_tvalid = 1'b1;
        bus.o_tready = 1'b1;
        #1;
        check("pre_rst_o_tvalid", 64'(bus.o_tvalid), 64'd1);
        ce_rst = 1'b0;
        #1;
        check("midrst_o_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("midrst_o_tlast", 64'(bus.o_tlast), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        repeat (2) @(posedge ce_clk);
        #1;
        bus.i_tvalid = 1'b0;
        ce_rst = 1'b1;
        repeat (20) send(1'b0);

        trig = longint'(ramp);
        last_val = trig + 64 + 20;
        build(trig, 64, 16, 0, 1, last_val, nfr);
        while (longint'(ramp) <= last_val) send(longint'(ramp) == trig);
        $display("defaults: frame_cnt=%0d busy=%0d", bus.frame_cnt, bus.busy);
        check("dflt_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        check("dflt_busy", 64'(bus.busy), 64'd0);
        check("dflt_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end
endmodule
